// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundle of the fetch stage's handshake and bus signals:
//               execute redirect, decode valid/stall/halt handshake and the
//               instruction-memory request/done port.
// Modports    : master - the fetch unit (drives imem request and decode side)
//               slave  - the environment (execute, decode and memory)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if;
    logic        redirect;
    logic [15:0] redirectPC;
    logic        stall;
    logic        halt;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic [15:0] imemRdata;
    logic        imemDone;
    logic [15:0] instr;
    logic        instrValid;
    logic [15:0] instrPC;
    logic [15:0] pcPlus2;
    logic        halted;
    logic        err;

    modport master (
        input  redirect, redirectPC, stall, halt, imemRdata, imemDone,
        output imemReq, imemAddr, instr, instrValid, instrPC, pcPlus2,
               halted, err
    );

    modport slave (
        output redirect, redirectPC, stall, halt, imemRdata, imemDone,
        input  imemReq, imemAddr, instr, instrValid, instrPC, pcPlus2,
               halted, err
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage of the 16-bit processor. Owns the PC,
//               issues one instruction-memory read at a time, buffers the
//               returned instruction for decode, follows execute redirects
//               (squashing in-flight reads) and freezes on HALT or on a
//               misaligned redirect target.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - fetch_unit_if.master (redirect, decode handshake,
//                      instruction-memory request/done)
// Parameters  : RESET_PC - PC loaded on reset
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_VALID  = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_pc;
    logic        r_pend_valid;
    logic [15:0] r_pend_pc;
    logic [15:0] r_instr;
    logic [15:0] r_instr_pc;
    logic [15:0] r_pc_plus2;
    logic        r_err;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic        r_halted;

    logic        w_bad_redirect;

    // A redirect to an odd address is fatal for the fetch stream.
    assign w_bad_redirect = bus.redirect & bus.redirectPC[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_pc     <= 16'h0000;
            r_instr       <= 16'h0000;
            r_instr_pc    <= 16'h0000;
            r_pc_plus2    <= 16'h0000;
            r_err         <= 1'b0;
            r_imem_req    <= 1'b1;
            r_instr_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_bad_redirect) begin
                        // Outstanding read is simply ignored once halted.
                        r_err         <= 1'b1;
                        r_pend_valid  <= 1'b0;
                        r_state       <= S_HALTED;
                        r_imem_req    <= 1'b0;
                        r_halted      <= 1'b1;
                    end else if (bus.imemDone) begin
                        if (bus.redirect) begin
                            r_pc         <= bus.redirectPC;
                            r_pend_valid <= 1'b0;
                        end else if (r_pend_valid) begin
                            // Stale data: reissue at the remembered target.
                            r_pc         <= r_pend_pc;
                            r_pend_valid <= 1'b0;
                        end else begin
                            r_instr       <= bus.imemRdata;
                            r_instr_pc    <= r_pc;
                            r_pc_plus2    <= r_pc + 16'd2;
                            r_pc          <= r_pc + 16'd2;
                            r_state       <= S_VALID;
                            r_imem_req    <= 1'b0;
                            r_instr_valid <= 1'b1;
                        end
                    end else if (bus.redirect) begin
                        // The read cannot be aborted, so the address stays
                        // put and the target is remembered; last one wins.
                        r_pend_pc    <= bus.redirectPC;
                        r_pend_valid <= 1'b1;
                    end
                end

                S_VALID: begin
                    if (w_bad_redirect) begin
                        r_err         <= 1'b1;
                        r_state       <= S_HALTED;
                        r_instr_valid <= 1'b0;
                        r_halted      <= 1'b1;
                    end else if (bus.redirect) begin
                        r_pc          <= bus.redirectPC;
                        r_state       <= S_REQ;
                        r_imem_req    <= 1'b1;
                        r_instr_valid <= 1'b0;
                    end else if (!bus.stall) begin
                        r_instr_valid <= 1'b0;
                        if (bus.halt) begin
                            r_state  <= S_HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            // PC was advanced when the instruction was captured.
                            r_state    <= S_REQ;
                            r_imem_req <= 1'b1;
                        end
                    end
                end

                S_HALTED: begin
                    // Frozen until reset.
                end

                default: begin
                    r_state       <= S_HALTED;
                    r_imem_req    <= 1'b0;
                    r_instr_valid <= 1'b0;
                    r_halted      <= 1'b1;
                end
            endcase
        end
    end

    assign bus.imemReq    = r_imem_req;
    assign bus.imemAddr   = r_pc;
    assign bus.instr      = r_instr;
    assign bus.instrValid = r_instr_valid;
    assign bus.instrPC    = r_instr_pc;
    assign bus.pcPlus2    = r_pc_plus2;
    assign bus.halted     = r_halted;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. Directed scenarios for
//               reset, sequential fetch, stall hold, redirects, squash, wrap,
//               halt, misalignment and asynchronous reset, followed by a
//               randomized run scored against a program-order model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory contents used in the randomized run.
    function automatic logic [15:0] mem_data(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Reference model state for the randomized run.
    logic [15:0] exp_pc;
    logic        exp_halted;
    logic        addr_stale;
    logic [15:0] tgt;
    int          mem_wait;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.redirect   = 1'b0;
        bus.redirectPC = 16'h0000;
        bus.stall      = 1'b0;
        bus.halt       = 1'b0;
        bus.imemDone   = 1'b0;
        bus.imemRdata  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;

        // ---- reset state
        check("rst_req",    16'(bus.imemReq), 16'd1);
        check("rst_addr",   bus.imemAddr, 16'h0000);
        check("rst_valid",  16'(bus.instrValid), 16'd0);
        check("rst_instr",  bus.instr, 16'h0000);
        check("rst_ipc",    bus.instrPC, 16'h0000);
        check("rst_pc2",    bus.pcPlus2, 16'h0000);
        check("rst_halted", 16'(bus.halted), 16'd0);
        check("rst_err",    16'(bus.err), 16'd0);
        rst = 1'b0;
        check("post_rst_req", 16'(bus.imemReq), 16'd1);

        // ---- sequential zero-wait fetch, addr-as-data
        for (int k = 0; k < 3; k++) begin
            bus.imemDone  = 1'b1;
            bus.imemRdata = bus.imemAddr;
            tick();
            bus.imemDone = 1'b0;
            check("seq_valid", 16'(bus.instrValid), 16'd1);
            check("seq_instr", bus.instr, 16'(k * 2));
            check("seq_ipc",   bus.instrPC, 16'(k * 2));
            check("seq_pc2",   bus.pcPlus2, 16'(k * 2 + 2));
            check("seq_noreq", 16'(bus.imemReq), 16'd0);
            if (k < 2) begin
                tick();
                check("seq_req",     16'(bus.imemReq), 16'd1);
                check("seq_addr",    bus.imemAddr, 16'(k * 2 + 2));
                check("seq_invalid", 16'(bus.instrValid), 16'd0);
            end
        end

        // ---- stall hold on instr 0004
        bus.stall = 1'b1;
        repeat (5) begin
            tick();
            check("stall_instr", bus.instr, 16'h0004);
            check("stall_ipc",   bus.instrPC, 16'h0004);
            check("stall_valid", 16'(bus.instrValid), 16'd1);
            check("stall_req",   16'(bus.imemReq), 16'd0);
        end
        bus.stall = 1'b0;
        tick();
        check("unstall_req",  16'(bus.imemReq), 16'd1);
        check("unstall_addr", bus.imemAddr, 16'h0006);

        // ---- redirect while a read is outstanding reaches 0010
        bus.redirect = 1'b1; bus.redirectPC = 16'h0010;
        tick();
        bus.redirect = 1'b0;
        check("pend_addr_hold", bus.imemAddr, 16'h0006);
        bus.imemDone = 1'b1; bus.imemRdata = 16'h0006;
        tick();
        bus.imemDone = 1'b0;
        check("pend_drop_valid", 16'(bus.instrValid), 16'd0);
        check("pend_new_addr",   bus.imemAddr, 16'h0010);
        bus.imemDone = 1'b1; bus.imemRdata = 16'h0010;
        tick();
        bus.imemDone = 1'b0;
        check("at10_ipc", bus.instrPC, 16'h0010);

        // ---- redirect in VALID beats stall
        bus.redirect = 1'b1; bus.redirectPC = 16'h0100; bus.stall = 1'b1;
        tick();
        bus.redirect = 1'b0; bus.stall = 1'b0;
        check("rdv_valid", 16'(bus.instrValid), 16'd0);
        check("rdv_req",   16'(bus.imemReq), 16'd1);
        check("rdv_addr",  bus.imemAddr, 16'h0100);

        // ---- redirect coincident with done discards data
        bus.imemDone = 1'b1; bus.imemRdata = 16'h0100;
        bus.redirect = 1'b1; bus.redirectPC = 16'h0020;
        tick();
        bus.imemDone = 1'b0; bus.redirect = 1'b0;
        check("rdd_valid", 16'(bus.instrValid), 16'd0);
        check("rdd_addr",  bus.imemAddr, 16'h0020);

        // ---- squash: 3 wait cycles, redirects in wait 1 and 2
        bus.redirect = 1'b1; bus.redirectPC = 16'h0200;
        tick();
        check("sq_addr1", bus.imemAddr, 16'h0020);
        bus.redirectPC = 16'h0300;
        tick();
        bus.redirect = 1'b0;
        check("sq_addr2", bus.imemAddr, 16'h0020);
        tick();
        bus.imemDone = 1'b1; bus.imemRdata = 16'h0020;
        tick();
        bus.imemDone = 1'b0;
        check("sq_valid", 16'(bus.instrValid), 16'd0);
        check("sq_req",   16'(bus.imemReq), 16'd1);
        check("sq_addr3", bus.imemAddr, 16'h0300);
        bus.imemDone = 1'b1; bus.imemRdata = 16'h0300;
        tick();
        bus.imemDone = 1'b0;
        check("sq_instr", bus.instr, 16'h0300);
        check("sq_ipc",   bus.instrPC, 16'h0300);

        // ---- wrap at FFFE then halt
        bus.redirect = 1'b1; bus.redirectPC = 16'hFFFE;
        tick();
        bus.redirect = 1'b0;
        check("wrap_addr", bus.imemAddr, 16'hFFFE);
        bus.imemDone = 1'b1; bus.imemRdata = 16'hFFFE;
        tick();
        bus.imemDone = 1'b0;
        check("wrap_ipc", bus.instrPC, 16'hFFFE);
        check("wrap_pc2", bus.pcPlus2, 16'h0000);
        check("wrap_err", 16'(bus.err), 16'd0);
        tick();
        check("wrap_next", bus.imemAddr, 16'h0000);
        check("wrap_req",  16'(bus.imemReq), 16'd1);
        bus.imemDone = 1'b1; bus.imemRdata = 16'h0000;
        tick();
        bus.imemDone = 1'b0;
        check("wrap_valid0", 16'(bus.instrValid), 16'd1);
        bus.halt = 1'b1;
        tick();
        bus.halt = 1'b0;
        check("halt_halted", 16'(bus.halted), 16'd1);
        check("halt_req",    16'(bus.imemReq), 16'd0);
        check("halt_valid",  16'(bus.instrValid), 16'd0);
        bus.redirect = 1'b1; bus.imemDone = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.redirectPC = (k == 2) ? 16'h0041 : 16'h0040;
            tick();
            check("halt_stay", 16'(bus.halted), 16'd1);
            check("halt_noreq", 16'(bus.imemReq), 16'd0);
            check("halt_noerr", 16'(bus.err), 16'd0);
        end
        bus.redirect = 1'b0; bus.imemDone = 1'b0;

        // ---- misaligned redirect
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.redirect = 1'b1; bus.redirectPC = 16'h0101;
        tick();
        bus.redirect = 1'b0;
        check("mis_err",    16'(bus.err), 16'd1);
        check("mis_halted", 16'(bus.halted), 16'd1);
        check("mis_req",    16'(bus.imemReq), 16'd0);
        bus.imemDone = 1'b1; bus.imemRdata = 16'h0000;
        tick();
        bus.imemDone = 1'b0;
        check("mis_drop", 16'(bus.instrValid), 16'd0);
        check("mis_sticky", 16'(bus.err), 16'd1);

        // ---- asynchronous reset in the middle of a wait
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.imemDone = 1'b1; bus.imemRdata = 16'h0000;
        tick();
        bus.imemDone = 1'b0;
        tick();
        check("mw_addr", bus.imemAddr, 16'h0002);
        tick();
        #2 rst = 1'b1;
        #1;
        check("ar_req",    16'(bus.imemReq), 16'd1);
        check("ar_addr",   bus.imemAddr, 16'h0000);
        check("ar_valid",  16'(bus.instrValid), 16'd0);
        check("ar_instr",  bus.instr, 16'h0000);
        check("ar_ipc",    bus.instrPC, 16'h0000);
        check("ar_pc2",    bus.pcPlus2, 16'h0000);
        check("ar_halted", 16'(bus.halted), 16'd0);
        check("ar_err",    16'(bus.err), 16'd0);
        tick();
        rst = 1'b0;

        // ---- randomized run against a program-order model
        exp_pc     = 16'h0000;
        exp_halted = 1'b0;
        addr_stale = 1'b0;
        mem_wait   = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            check("r_err", 16'(bus.err), 16'd0);
            if (exp_halted) begin
                check("r_halted",  16'(bus.halted), 16'd1);
                check("r_h_noreq", 16'(bus.imemReq), 16'd0);
                check("r_h_inval", 16'(bus.instrValid), 16'd0);
            end else begin
                check("r_nohalt", 16'(bus.halted), 16'd0);
                if (bus.instrValid) begin
                    check("r_ipc",   bus.instrPC, exp_pc);
                    check("r_instr", bus.instr, mem_data(exp_pc));
                    check("r_pc2",   bus.pcPlus2, exp_pc + 16'd2);
                    check("r_excl",  16'(bus.imemReq), 16'd0);
                end
                if (bus.imemReq && !addr_stale)
                    check("r_addr", bus.imemAddr, exp_pc);
            end

            bus.stall    = ($urandom_range(0, 2) == 0);
            bus.halt     = ($urandom_range(0, 3) == 0) && (cyc > 1400 || !bus.instrValid);
            bus.redirect = ($urandom_range(0, 7) == 0);
            tgt          = 16'($urandom);
            tgt[0]       = 1'b0;
            bus.redirectPC = tgt;
            if (bus.imemReq) begin
                if (mem_wait == 0) begin
                    bus.imemDone  = 1'b1;
                    bus.imemRdata = mem_data(bus.imemAddr);
                    mem_wait      = $urandom_range(0, 3);
                end else begin
                    bus.imemDone = 1'b0;
                    mem_wait--;
                end
            end else begin
                bus.imemDone = 1'b0;
            end

            // Next presented instruction follows program order unless redirected.
            if (!exp_halted) begin
                if (bus.redirect) begin
                    exp_pc     = tgt;
                    addr_stale = bus.imemReq && !bus.imemDone;
                end else if (bus.instrValid && !bus.stall) begin
                    if (bus.halt) exp_halted = 1'b1;
                    else          exp_pc = exp_pc + 16'd2;
                end else if (bus.imemReq && bus.imemDone) begin
                    addr_stale = 1'b0;
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the 16-bit processor. It owns the architectural PC and issues one instruction-memory read at a time over a variable-latency request/done handshake. It presents the fetched instruction to decode with a valid/stall handshake. It is the consumer of the execute stage's resolved next-PC: it takes redirects for taken branches and jumps, squashes stale fetches, and freezes on HALT.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- redirect  in  1  execute resolved a taken branch/jump/jump-register this cycle.
- redirectPC  in  16  target address from execute's nextPC.
- stall  in  1  decode cannot accept the presented instruction this cycle.
- halt  in  1  presented instruction is HALT; sampled only on a consume cycle.
- imemReq  out  1  read request outstanding.
- imemAddr  out  16  read address; stable while imemReq=1.
- imemRdata  in  16  read data; valid when imemDone=1.
- imemDone  in  1  memory completes the outstanding read this cycle.
- instr  out  16  buffered instruction.
- instrValid  out  1  instr/instrPC/pcPlus2 valid.
- instrPC  out  16  address of instr.
- pcPlus2  out  16  instrPC+2 (link value for JAL/JALR).
- halted  out  1  fetch frozen.
- err  out  1  sticky: misaligned redirect target.

## Operation
- Registers: pc[15:0], state, pendValid, pendPC[15:0], instr buffer, instrPC, pcPlus2, err.
- State REQ: imemReq=1, imemAddr=pc.
  - On imemDone with no redirect this cycle and pendValid=0: capture imemRdata→instr, pc→instrPC, pc+2→pcPlus2 and pc. Go to VALID.
  - On imemDone with redirect this cycle: discard data, pc←redirectPC, clear pendValid, stay REQ.
  - On imemDone with pendValid=1 and no redirect: discard data, pc←pendPC, clear pendValid, stay REQ.
  - On redirect without imemDone: pendPC←redirectPC, pendValid←1. imemAddr does not change, because memory requests cannot be aborted. If several redirects arrive, the last one wins.
- State VALID: instrValid=1, imemReq=0.
  - redirect: invalidate buffer, pc←redirectPC, go REQ. This has priority over stall and halt.
  - No redirect, stall=0, halt=1: instruction consumed, go HALTED.
  - No redirect, stall=0, halt=0: instruction consumed, go REQ (pc already +2).
  - stall=1: hold all outputs unchanged.
- State HALTED: imemReq=0, instrValid=0, halted=1. Redirect and halt are ignored; the only exit is rst.
- Misaligned redirect (redirectPC[0]=1) in any state except HALTED: err←1 (sticky) and go HALTED next cycle. Any outstanding response is dropped when it arrives.
- Arithmetic: pc+2 is modulo 2^16, so 16'hFFFE wraps to 16'h0000 with no error. instrPC and pcPlus2 are never flagged.

## Timing
- Reset values while rst=1: state=REQ, pc=RESET_PC, pendValid=0, instr=0, instrValid=0, instrPC=0, pcPlus2=0, halted=0, err=0. imemReq=1 and imemAddr=RESET_PC are driven during reset and in the first cycle after.
- Outputs are decoded from registered state only; there is no combinational path from inputs to outputs.
- Zero-wait memory (imemDone in the first request cycle N): instrValid=1 in cycle N+1.
- Peak throughput is 1 instruction per 2 cycles. Each additional memory wait cycle adds 1 cycle.
- Redirect in cycle N while in VALID: new request at redirectPC in cycle N+1.
- Redirect during an outstanding request: the redirected request issues the cycle after imemDone.
- rst asserted mid-request: state returns to REQ immediately. A late imemDone for the aborted request is the memory's responsibility and is not filtered here.

## Test plan
- Reset/sequential: RESET_PC=16'h0000, memory returns addr-as-data with 0 wait, stall=0 → instr 0000,0002,0004 presented with instrValid on alternate cycles; pcPlus2=instrPC+2.
- Stall hold: stall=1 for 5 cycles while instr=16'h0004 is valid → instr, instrPC, instrValid unchanged and imemReq=0; release → next imemAddr=16'h0006.
- Redirect in VALID: instrPC=16'h0010 valid, redirect=1, redirectPC=16'h0100 → instrValid=0 next cycle, imemAddr=16'h0100.
- Squash: request to 16'h0020 with 3 wait cycles, redirect to 16'h0200 in wait cycle 1 and to 16'h0300 in wait cycle 2 → 0020 data never presented; next request is 16'h0300.
- Wrap and halt: fetch at 16'hFFFE → pcPlus2=16'h0000, next imemAddr=16'h0000, err=0. Consume with halt=1 → halted=1, imemReq=0 indefinitely, and a subsequent redirect is ignored.
- Misaligned: redirectPC=16'h0101 → err=1 and halted=1 the next cycle. Reset mid-wait → all outputs return to their reset values and imemAddr=RESET_PC.
